// File: rtl/usr_seq_ctrl.sv
// usr_seq_ctrl: command sequencer for a universal shift register (usr).
// Takes one command per valid/ready handshake, then drives the usr control pins:
// parallel load, N shift (or wait) cycles, then capture of usr_y into o_result.
// Optional build macro USR_SEQ_ROTATE_EN: in SHIFT the serial fill is taken from
// usr_y (rotate) instead of the latched cmd_fill bit.
module usr_seq_ctrl #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 3
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_cmd_valid,
  output logic             o_cmd_ready,
  input  logic [1:0]       i_cmd_op,
  input  logic [WIDTH-1:0] i_cmd_data,
  input  logic [CNT_W-1:0] i_cmd_cnt,
  input  logic             i_cmd_fill,
  input  logic             i_abort,
  output logic [1:0]       o_usr_sel,
  output logic [WIDTH-1:0] o_usr_in,
  input  logic [WIDTH-1:0] i_usr_y,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_result
);

  typedef enum logic [1:0] {StIdle, StLoad, StShift, StCapt} state_e;

  localparam logic [1:0] OpWait  = 2'b00;
  localparam logic [1:0] OpRight = 2'b01;
  localparam logic [1:0] OpLeft  = 2'b10;
  localparam logic [1:0] OpLoad  = 2'b11;

  state_e           r_state;
  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_data;
  logic [CNT_W-1:0] r_cnt;
  logic             r_done;
  logic [WIDTH-1:0] r_result;
  logic             w_fill;

`ifndef USR_SEQ_ROTATE_EN
  logic             r_fill;

  // Latched fill bit for logical shift with fill.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_fill <= 1'b0;
    end else if (r_state == StIdle && i_cmd_valid && !i_abort) begin
      r_fill <= i_cmd_fill;
    end
  end
`endif

  // Command FSM: accept, load, shift/wait count, capture; abort returns to idle silently.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state  <= StIdle;
      r_op     <= OpWait;
      r_data   <= '0;
      r_cnt    <= '0;
      r_done   <= 1'b0;
      r_result <= '0;
    end else begin
      r_done <= 1'b0;
      if (r_state == StIdle) begin
        // abort alongside valid blocks acceptance
        if (i_cmd_valid && !i_abort) begin
          r_op   <= i_cmd_op;
          r_data <= i_cmd_data;
          r_cnt  <= i_cmd_cnt;
          if (i_cmd_op != OpWait) begin
            r_state <= StLoad;
          end else if (i_cmd_cnt != '0) begin
            r_state <= StShift;
          end else begin
            r_state <= StCapt;
          end
        end
      end else if (i_abort) begin
        r_state <= StIdle;
      end else begin
        unique case (r_state)
          StLoad: begin
            if (r_cnt != '0 && r_op != OpLoad) begin
              r_state <= StShift;
            end else begin
              r_state <= StCapt;
            end
          end
          StShift: begin
            // saturating decrement; leave on the cycle the count reads 1
            if (r_cnt != '0) begin
              r_cnt <= r_cnt - CNT_W'(1);
            end
            if (r_cnt <= CNT_W'(1)) begin
              r_state <= StCapt;
            end
          end
          StCapt: begin
            r_result <= i_usr_y;
            r_done   <= 1'b1;
            r_state  <= StIdle;
          end
          default: r_state <= StIdle;
        endcase
      end
    end
  end

  // Serial fill source: rotate taps usr_y, otherwise the latched command bit.
  always_comb begin
    w_fill = 1'b0;
`ifdef USR_SEQ_ROTATE_EN
    if (r_op == OpLeft) begin
      w_fill = i_usr_y[WIDTH-1];
    end else begin
      w_fill = i_usr_y[0];
    end
`else
    w_fill = r_fill;
`endif
  end

  // usr control decode from registered state; fill replicated so either serial tap sees it.
  always_comb begin
    o_usr_sel = 2'b00;
    o_usr_in  = '0;
    unique case (r_state)
      StLoad: begin
        o_usr_sel = 2'b11;
        o_usr_in  = r_data;
      end
      StShift: begin
        if (r_op == OpRight) begin
          o_usr_sel = 2'b01;
        end else if (r_op == OpLeft) begin
          o_usr_sel = 2'b10;
        end else begin
          o_usr_sel = 2'b00;
        end
        o_usr_in = {WIDTH{w_fill}};
      end
      default: begin
        o_usr_sel = 2'b00;
        o_usr_in  = '0;
      end
    endcase
  end

  assign o_cmd_ready = (r_state == StIdle);
  assign o_busy      = (r_state != StIdle);
  assign o_done      = r_done;
  assign o_result    = r_result;

endmodule
